ex_stage: RTL and testbench

- Execute stage of the five-stage pipeline: consumes the ID/EX pipeline-register outputs and computes the ALU result.
- Drives the registered EX/MEM boundary.
- Single-cycle ops complete with 1-cycle latency.
- Unsigned divide/remainder runs on an iterative 32-step divider; `ex_stall` holds the upstream pipeline while the divider is busy.

---
 rtl/ex_stage_pkg.sv | 60 ++++++
 rtl/ex_divider.sv | 73 +++++++
 rtl/ex_stage.sv | 118 +++++++++++
 tb/tb_ex_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op codes, divider state encoding and the EX/MEM payload.
// Consumed by ex_stage and by ex_divider (compiled when EX_DIV_EN is defined).
package ex_stage_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam int unsigned ALU_OP_BUS   = 8;
    localparam int unsigned SHAMT_W      = 5;

    localparam logic [ALU_OP_BUS-1:0] OP_ADD  = 8'h00;
    localparam logic [ALU_OP_BUS-1:0] OP_SUB  = 8'h01;
    localparam logic [ALU_OP_BUS-1:0] OP_AND  = 8'h02;
    localparam logic [ALU_OP_BUS-1:0] OP_OR   = 8'h03;
    localparam logic [ALU_OP_BUS-1:0] OP_XOR  = 8'h04;
    localparam logic [ALU_OP_BUS-1:0] OP_SLL  = 8'h05;
    localparam logic [ALU_OP_BUS-1:0] OP_SRL  = 8'h06;
    localparam logic [ALU_OP_BUS-1:0] OP_SRA  = 8'h07;
    localparam logic [ALU_OP_BUS-1:0] OP_SLT  = 8'h08;
    localparam logic [ALU_OP_BUS-1:0] OP_SLTU = 8'h09;
    localparam logic [ALU_OP_BUS-1:0] OP_DIVU = 8'h0A;
    localparam logic [ALU_OP_BUS-1:0] OP_REMU = 8'h0B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic                    we;
        logic [REG_ADDR_BUS-1:0] waddr;
        logic [REG_BUS-1:0]      result;
        logic                    re;
        logic                    mem_we;
    } ex_mem_t;

    // Single-cycle ALU; divide ops and unknown codes fall to zero here.
    function automatic logic [REG_BUS-1:0] alu_calc(
        input logic [ALU_OP_BUS-1:0] op,
        input logic [REG_BUS-1:0]    a,
        input logic [REG_BUS-1:0]    b
    );
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  return REG_BUS'(a + b);
            OP_SUB:  return REG_BUS'(a - b);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return REG_BUS'(a << sh);
            OP_SRL:  return REG_BUS'(a >> sh);
            OP_SRA:  return REG_BUS'($signed(a) >>> sh);
            OP_SLT:  return REG_BUS'($signed(a) < $signed(b));
            OP_SLTU: return REG_BUS'(a < b);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ex_divider.sv
// 32-step unsigned restoring divider with IDLE/BUSY/DONE control.
// Only compiled when EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [REG_BUS-1:0] dividend,
    input  logic [REG_BUS-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [REG_BUS-1:0] quotient,
    output logic [REG_BUS-1:0] remainder
);

    localparam int unsigned CNT_W = 5;

    div_state_e           r_state;
    logic [CNT_W-1:0]     r_count;
    logic [REG_BUS-1:0]   r_quo;
    logic [REG_BUS-1:0]   r_rem;
    logic [REG_BUS-1:0]   r_dvs;

    logic [REG_BUS:0]     w_shift;
    logic [REG_BUS-1:0]   w_diff;
    logic                 w_ge;

    // Partial remainder shifted left with the next dividend bit; a zero divisor always subtracts.
    assign w_shift = {r_rem, r_quo[REG_BUS-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[REG_BUS-1:0] - r_dvs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
            r_count <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_quo   <= dividend;
                        r_dvs   <= divisor;
                        r_rem   <= '0;
                        r_count <= '0;
                        r_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    r_quo   <= {r_quo[REG_BUS-2:0], w_ge};
                    r_rem   <= w_ge ? w_diff : w_shift[REG_BUS-1:0];
                    r_count <= CNT_W'(r_count + 1'b1);
                    if (r_count == CNT_W'(REG_BUS - 1)) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == DIV_BUSY);
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, divider stall control and the EX/MEM register.
// Define EX_DIV_EN to build the iterative DIVU/REMU divider; otherwise they act as undefined ops.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_regfile_we,
    input  logic [REG_ADDR_BUS-1:0] ex_regfile_waddr,
    input  logic [ALU_OP_BUS-1:0]   ex_alu_op,
    input  logic [REG_BUS-1:0]      ex_alu_src1,
    input  logic [REG_BUS-1:0]      ex_alu_src2,
    input  logic                    ex_mem_re,
    input  logic                    ex_mem_we,
    output logic                    ex_stall,
    output logic                    mem_regfile_we,
    output logic [REG_ADDR_BUS-1:0] mem_regfile_waddr,
    output logic [REG_BUS-1:0]      mem_alu_result,
    output logic                    mem_mem_re,
    output logic                    mem_mem_we
);

    logic [REG_BUS-1:0] w_alu_result;
    ex_mem_t            w_next;
    ex_mem_t            r_exmem;

    assign w_alu_result = alu_calc(ex_alu_op, ex_alu_src1, ex_alu_src2);

`ifdef EX_DIV_EN
    logic                    w_is_div;
    logic                    w_start;
    logic                    w_busy;
    logic                    w_done;
    logic [REG_BUS-1:0]      w_quo;
    logic [REG_BUS-1:0]      w_rem;
    logic                    r_div_we;
    logic [REG_ADDR_BUS-1:0] r_div_waddr;
    logic                    r_div_re;
    logic                    r_div_mem_we;
    logic                    r_div_is_rem;

    assign w_is_div = (ex_alu_op == OP_DIVU) || (ex_alu_op == OP_REMU);
    assign w_start  = w_is_div && !w_busy && !w_done;
    assign ex_stall = rst && (w_start || w_busy);

    ex_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .dividend  (ex_alu_src1),
        .divisor   (ex_alu_src2),
        .busy      (w_busy),
        .done      (w_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Control bits are captured with the operands so DONE never looks at the live inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_we     <= 1'b0;
            r_div_waddr  <= '0;
            r_div_re     <= 1'b0;
            r_div_mem_we <= 1'b0;
            r_div_is_rem <= 1'b0;
        end else if (w_start) begin
            r_div_we     <= ex_regfile_we;
            r_div_waddr  <= ex_regfile_waddr;
            r_div_re     <= ex_mem_re;
            r_div_mem_we <= ex_mem_we;
            r_div_is_rem <= (ex_alu_op == OP_REMU);
        end
    end

    always_comb begin
        w_next = '0;
        if (w_done) begin
            w_next.we     = r_div_we;
            w_next.waddr  = r_div_waddr;
            w_next.result = r_div_is_rem ? w_rem : w_quo;
            w_next.re     = r_div_re;
            w_next.mem_we = r_div_mem_we;
        end else if (!ex_stall) begin
            w_next.we     = ex_regfile_we;
            w_next.waddr  = ex_regfile_waddr;
            w_next.result = w_alu_result;
            w_next.re     = ex_mem_re;
            w_next.mem_we = ex_mem_we;
        end
    end
`else
    assign ex_stall = 1'b0;

    always_comb begin
        w_next        = '0;
        w_next.we     = ex_regfile_we;
        w_next.waddr  = ex_regfile_waddr;
        w_next.result = w_alu_result;
        w_next.re     = ex_mem_re;
        w_next.mem_we = ex_mem_we;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_next;
        end
    end

    assign mem_regfile_we    = r_exmem.we;
    assign mem_regfile_waddr = r_exmem.waddr;
    assign mem_alu_result    = r_exmem.result;
    assign mem_mem_re        = r_exmem.re;
    assign mem_mem_we        = r_exmem.mem_we;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU vector table through a scoreboard, async reset,
// and (with EX_DIV_EN) divider latency, divide-by-zero and reset-during-divide sequences.
module tb_ex_stage;

    localparam logic [7:0] ADD = 8'h00, SUB = 8'h01, AND_ = 8'h02, OR_ = 8'h03, XOR_ = 8'h04;
    localparam logic [7:0] SLL = 8'h05, SRL = 8'h06, SRA = 8'h07, SLT = 8'h08, SLTU = 8'h09;
    localparam logic [7:0] DIVU = 8'h0A, REMU = 8'h0B;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] res;
        logic        re;
        logic        mwe;
    } exp_t;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [4:0]  waddr;
        logic        re;
        logic        mwe;
        logic [31:0] res;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_regfile_we;
    logic [4:0]  ex_regfile_waddr;
    logic [7:0]  ex_alu_op;
    logic [31:0] ex_alu_src1;
    logic [31:0] ex_alu_src2;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic        ex_stall;
    logic        mem_regfile_we;
    logic [4:0]  mem_regfile_waddr;
    logic [31:0] mem_alu_result;
    logic        mem_mem_re;
    logic        mem_mem_we;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    tv_t  vecs[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_regfile_we     (ex_regfile_we),
        .ex_regfile_waddr  (ex_regfile_waddr),
        .ex_alu_op         (ex_alu_op),
        .ex_alu_src1       (ex_alu_src1),
        .ex_alu_src2       (ex_alu_src2),
        .ex_mem_re         (ex_mem_re),
        .ex_mem_we         (ex_mem_we),
        .ex_stall          (ex_stall),
        .mem_regfile_we    (mem_regfile_we),
        .mem_regfile_waddr (mem_regfile_waddr),
        .mem_alu_result    (mem_alu_result),
        .mem_mem_re        (mem_mem_re),
        .mem_mem_we        (mem_mem_we)
    );

    function automatic tv_t mk(string name, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                               logic we, logic [4:0] waddr, logic re, logic mwe, logic [31:0] res);
        tv_t t;
        t.name = name; t.op = op; t.a = a; t.b = b; t.we = we;
        t.waddr = waddr; t.re = re; t.mwe = mwe; t.res = res;
        return t;
    endfunction

    task automatic drive(logic [7:0] op, logic [31:0] a, logic [31:0] b,
                         logic we, logic [4:0] waddr, logic re, logic mwe);
        ex_alu_op = op; ex_alu_src1 = a; ex_alu_src2 = b;
        ex_regfile_we = we; ex_regfile_waddr = waddr; ex_mem_re = re; ex_mem_we = mwe;
    endtask

    task automatic check_stall(string name, logic es);
        n_cmp++;
        if (ex_stall !== es) begin
            n_err++;
            $display("FAIL %s: ex_stall got %0b want %0b", name, ex_stall, es);
        end
    endtask

    task automatic check(string name, exp_t e, logic es, logic chk_stall);
        exp_t act;
        act = {mem_regfile_we, mem_regfile_waddr, mem_alu_result, mem_mem_re, mem_mem_we};
        n_cmp++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got we=%0b waddr=%0d res=%h re=%0b mwe=%0b, want we=%0b waddr=%0d res=%h re=%0b mwe=%0b",
                     name, act.we, act.waddr, act.res, act.re, act.mwe, e.we, e.waddr, e.res, e.re, e.mwe);
        end
        if (chk_stall) check_stall(name, es);
    endtask

`ifdef EX_DIV_EN
    // Caller is at a negedge; returns at the negedge where the result is visible.
    task automatic run_div(string name, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                           logic [4:0] waddr, logic [31:0] res);
        exp_t e;
        drive(op, a, b, 1'b1, waddr, 1'b0, 1'b0);
        #1 check_stall({name, "_stall_n"}, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k <= 33) begin
                sb.push_back('0);
                e = sb.pop_front();
                check($sformatf("%s_bubble%0d", name, k), e, (k <= 32), 1'b1);
            end else begin
                sb.push_back({1'b1, waddr, res, 1'b0, 1'b0});
                e = sb.pop_front();
                check({name, "_result"}, e, 1'b0, 1'b0);
            end
        end
    endtask
`endif

    initial begin
        exp_t e;
        rst = 1'b0;
        drive(ADD, 32'h1, 32'h2, 1'b1, 5'd3, 1'b1, 1'b1);
        #12 check("reset_state", '0, 1'b0, 1'b1);
        @(negedge clk) rst = 1'b1;

        vecs.push_back(mk("add_ovf", ADD,  32'h7FFFFFFF, 32'h1,        1, 5'd3,  0, 0, 32'h80000000));
        vecs.push_back(mk("sub_wrap",SUB,  32'h0,        32'h1,        1, 5'd31, 0, 0, 32'hFFFFFFFF));
        vecs.push_back(mk("and",     AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 5'd1,  0, 0, 32'h00F000F0));
        vecs.push_back(mk("or",      OR_,  32'h12340000, 32'h00005678, 1, 5'd2,  0, 0, 32'h12345678));
        vecs.push_back(mk("xor",     XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 1, 5'd4,  0, 0, 32'hF0F00F0F));
        vecs.push_back(mk("sll_mask",SLL,  32'h00000001, 32'h0000003F, 1, 5'd5,  0, 0, 32'h80000000));
        vecs.push_back(mk("srl",     SRL,  32'h80000000, 32'h4,        1, 5'd6,  0, 0, 32'h08000000));
        vecs.push_back(mk("sra",     SRA,  32'h80000000, 32'h4,        1, 5'd7,  0, 0, 32'hF8000000));
        vecs.push_back(mk("slt_neg", SLT,  32'hFFFFFFFF, 32'h1,        1, 5'd8,  0, 0, 32'h1));
        vecs.push_back(mk("sltu_big",SLTU, 32'hFFFFFFFF, 32'h1,        1, 5'd9,  0, 0, 32'h0));
        vecs.push_back(mk("slt_pos", SLT,  32'h1,        32'hFFFFFFFF, 1, 5'd10, 0, 0, 32'h0));
        vecs.push_back(mk("sltu_sm", SLTU, 32'h1,        32'hFFFFFFFF, 1, 5'd11, 0, 0, 32'h1));
        vecs.push_back(mk("load",    ADD,  32'h00001000, 32'h10,       1, 5'd12, 1, 0, 32'h00001010));
        vecs.push_back(mk("store",   ADD,  32'h00002000, 32'h4,        0, 5'd0,  0, 1, 32'h00002004));
        vecs.push_back(mk("undef",   8'hFF,32'hDEADBEEF, 32'h1234,     0, 5'd9,  1, 1, 32'h0));
        vecs.push_back(mk("bubble",  ADD,  32'h0,        32'h0,        0, 5'd0,  0, 0, 32'h0));
`ifndef EX_DIV_EN
        vecs.push_back(mk("divu_off",DIVU, 32'd100,      32'd7,        1, 5'd5,  0, 0, 32'h0));
        vecs.push_back(mk("remu_off",REMU, 32'd100,      32'd7,        1, 5'd6,  0, 0, 32'h0));
`endif

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].waddr, vecs[i].re, vecs[i].mwe);
            sb.push_back({vecs[i].we, vecs[i].waddr, vecs[i].res, vecs[i].re, vecs[i].mwe});
            @(negedge clk);
            e = sb.pop_front();
            check(vecs[i].name, e, 1'b0, 1'b1);
        end

        // Asynchronous reset in mid-cycle, away from any clock edge.
        drive(ADD, 32'd5, 32'd6, 1'b1, 5'd7, 1'b1, 1'b1);
        @(posedge clk);
        #2 check("pre_reset", {1'b1, 5'd7, 32'd11, 1'b1, 1'b1}, 1'b0, 1'b1);
        rst = 1'b0;
        #1 check("async_reset", '0, 1'b0, 1'b1);
        @(negedge clk);
        check("reset_held", '0, 1'b0, 1'b1);
        rst = 1'b1;

`ifdef EX_DIV_EN
        drive(ADD, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        run_div("divu_100_7", DIVU, 32'd100,  32'd7, 5'd5, 32'd14);
        run_div("remu_100_7", REMU, 32'd100,  32'd7, 5'd6, 32'd2);
        run_div("divu_by0",   DIVU, 32'd1234, 32'd0, 5'd7, 32'hFFFFFFFF);
        run_div("remu_by0",   REMU, 32'd1234, 32'd0, 5'd8, 32'd1234);
        run_div("divu_max",   DIVU, 32'hFFFFFFFF, 32'd16, 5'd9, 32'h0FFFFFFF);

        // Reset while the divider is busy: nothing may be written back afterwards.
        drive(DIVU, 32'd100, 32'd7, 1'b1, 5'd5, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("div_abort", '0, 1'b0, 1'b1);
        drive(ADD, 32'd2, 32'd3, 1'b1, 5'd4, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b1;
        #1 check_stall("post_abort_stall", 1'b0);
        @(negedge clk);
        check("post_abort_add", {1'b1, 5'd4, 32'd5, 1'b0, 1'b0}, 1'b0, 1'b1);
        drive(ADD, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("post_abort_idle%0d", k), '0, 1'b0, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
